// File: rtl/tap_scan_master.sv
// ---------------------------------------------------------------------------
// tap_scan_master
//   Tester-side JTAG initiator. Takes host commands (TAP reset, IR scan,
//   DR scan, run-test idle) over a valid/ready handshake, walks the target's
//   IEEE 1149.1 TAP by driving tms, serialises the payload on tdi LSB-first
//   and collects tdo into a response word.
//
// Ports
//   tck        : single clock; the target TAP runs on the same edge
//   trst       : synchronous, active-high reset; abandons any command
//   cmd_valid  : host command valid
//   cmd_ready  : master can accept a command
//   cmd_op     : 00 TAP reset, 01 IR scan, 10 DR scan, 11 idle cycles
//   cmd_len    : bit count for scans, cycle count for idle
//   cmd_data   : tdi payload, bit 0 shifted first
//   tms, tdi   : registered drives to the target TAP
//   tdo        : serial data returned by the target
//   rsp_valid  : one-cycle pulse when a command completes
//   rsp_err    : qualifies rsp_valid; set for an illegal scan length
//   rsp_data   : captured tdo, bit k = kth bit shifted out, upper bits 0
//   busy       : command in progress
// ---------------------------------------------------------------------------
module tap_scan_master #(
    parameter int MAX_LEN = 128,
    parameter int LEN_W   = 8
) (
    input  logic               tck,
    input  logic               trst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RST      = 3'd1;
    localparam logic [2:0] S_PRE      = 3'd2;
    localparam logic [2:0] S_SHIFT    = 3'd3;
    localparam logic [2:0] S_POST     = 3'd4;
    localparam logic [2:0] S_RTI_WAIT = 3'd5;
    localparam logic [2:0] S_RESP     = 3'd6;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_IDLE  = 2'b11;

    localparam int               IDX_W    = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] RST_LAST = LEN_W'(4);

    // Control state (reset)
    logic [2:0]         state_q, state_d;
    logic               at_tlr_q, at_tlr_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
    logic               cap_q, cap_d;

    // Datapath state (loaded on accept before it is ever read)
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] rx_q, rx_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         pre_pat_q, pre_pat_d;
    logic [2:0]         pre_left_q, pre_left_d;
    logic [IDX_W-1:0]   cap_idx_q, cap_idx_d;
    logic               err_q, err_d;

    logic [4:0]         pre_seq;
    logic [2:0]         pre_n;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        at_tlr_d    = at_tlr_q;
        tms_d       = at_tlr_q;   // idle drive: hold TLR or sit in RTI
        tdi_d       = 1'b0;
        cmd_ready_d = 1'b0;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        cap_d       = 1'b0;
        len_d       = len_q;
        data_d      = data_q;
        rx_d        = rx_q;
        cnt_d       = cnt_q;
        pre_pat_d   = pre_pat_q;
        pre_left_d  = pre_left_q;
        cap_idx_d   = cap_idx_q;
        err_d       = err_q;
        pre_seq     = 5'b00000;
        pre_n       = 3'd0;

        // The bit presented last cycle has just been consumed by the target;
        // its tdo is valid at this edge.
        if (cap_q) begin
            rx_d[cap_idx_q] = tdo;
        end

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    len_d       = cmd_len;
                    data_d      = cmd_data;
                    rx_d        = '0;
                    err_d       = 1'b0;
                    case (cmd_op)
                        OP_RESET: begin
                            tms_d   = 1'b1;
                            cnt_d   = LEN_ONE;
                            state_d = S_RST;
                        end
                        OP_IDLE: begin
                            cnt_d = '0;
                            if (at_tlr_q) begin
                                tms_d    = 1'b0;
                                at_tlr_d = 1'b0;
                            end
                            state_d = (cmd_len == '0) ? S_RESP : S_RTI_WAIT;
                        end
                        default: begin
                            if ((cmd_len == '0) || (cmd_len > LEN_MAX)) begin
                                // No TAP activity; tms keeps its idle value.
                                err_d   = 1'b1;
                                state_d = S_RESP;
                            end else begin
                                // tms walk to Shift-xR, emitted LSB first.
                                pre_seq = (cmd_op == OP_IR) ? 5'b00011 : 5'b00001;
                                pre_n   = (cmd_op == OP_IR) ? 3'd4 : 3'd3;
                                if (at_tlr_q) begin
                                    pre_seq  = {pre_seq[3:0], 1'b0};
                                    pre_n    = pre_n + 3'd1;
                                    at_tlr_d = 1'b0;
                                end
                                tms_d      = pre_seq[0];
                                pre_pat_d  = {1'b0, pre_seq[4:1]};
                                pre_left_d = pre_n - 3'd1;
                                state_d    = S_PRE;
                            end
                        end
                    endcase
                end
            end

            S_RST: begin
                tms_d = 1'b1;
                cnt_d = cnt_q + LEN_ONE;
                if (cnt_q == RST_LAST) begin
                    at_tlr_d = 1'b1;
                    state_d  = S_RESP;
                end
            end

            S_PRE: begin
                tms_d      = pre_pat_q[0];
                pre_pat_d  = {1'b0, pre_pat_q[4:1]};
                pre_left_d = pre_left_q - 3'd1;
                if (pre_left_q == 3'd1) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                tdi_d     = data_q[0];
                data_d    = {1'b0, data_q[MAX_LEN-1:1]};
                cap_d     = 1'b1;
                cap_idx_d = cnt_q[IDX_W-1:0];
                tms_d     = 1'b0;
                cnt_d     = cnt_q + LEN_ONE;
                // Last bit leaves on the Exit1 transition.
                if (cnt_q == len_q - LEN_ONE) begin
                    tms_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_POST;
                end
            end

            S_POST: begin
                if (cnt_q == '0) begin
                    tms_d = 1'b1;       // Exit1 -> Update
                    cnt_d = LEN_ONE;
                end else begin
                    tms_d   = 1'b0;     // Update -> RTI
                    state_d = S_RESP;
                end
            end

            S_RTI_WAIT: begin
                tms_d = 1'b0;
                cnt_d = cnt_q + LEN_ONE;
                if (cnt_q + LEN_ONE == len_q) begin
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                if (!err_q) begin
                    rsp_data_d = rx_q;
                end
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge tck) begin
        if (trst) begin
            state_q     <= S_IDLE;
            at_tlr_q    <= 1'b1;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            cap_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            at_tlr_q    <= at_tlr_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            cap_q       <= cap_d;
        end
    end

    // NOTE: payload, shift and counter registers carry no reset; each is
    // written on command accept or state entry before it is read.
    always_ff @(posedge tck) begin
        len_q      <= len_d;
        data_q     <= data_d;
        rx_q       <= rx_d;
        cnt_q      <= cnt_d;
        pre_pat_q  <= pre_pat_d;
        pre_left_q <= pre_left_d;
        cap_idx_q  <= cap_idx_d;
        err_q      <= err_d;
    end

    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_tap_scan_master.sv
// ---------------------------------------------------------------------------
// tb_tap_scan_master
//   Directed bench for tap_scan_master. A behavioural target TAP (16-state
//   controller, 4-bit IR capturing 0x1, DR of selectable length) sits on the
//   tms/tdi/tdo pins. Each command's tms stream, latency and response are
//   compared with hand-computed values.
// ---------------------------------------------------------------------------
module tb_tap_scan_master;

    localparam int MAX_LEN = 128;
    localparam int LEN_W   = 8;

    logic               tck = 1'b0;
    logic               trst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = 2'b00;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               tms;
    logic               tdi;
    logic               tdo;
    logic               rsp_valid;
    logic               rsp_err;
    logic [MAX_LEN-1:0] rsp_data;
    logic               busy;

    tap_scan_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .tck       (tck),
        .trst      (trst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 tck = ~tck;

    // ------------------------------------------------------------------
    // Target TAP model
    // ------------------------------------------------------------------
    typedef enum logic [3:0] {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
        SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
    } tap_e;

    tap_e         tap = RTI;
    logic [127:0] dr_sr = '0;
    logic [127:0] dr_reg = '0;
    logic [127:0] dr_cap = '0;
    int           dr_len = 8;
    logic [3:0]   ir_sr = '0;
    logic [3:0]   ir_reg = '0;

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PADR;
            PADR:  return m ? EX2DR : PADR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PAIR;
            PAIR:  return m ? EX2IR : PAIR;
            EX2IR: return m ? UPIR  : SHIR;
            UPIR:  return m ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    function automatic logic [127:0] dr_shift(input logic [127:0] v, input int len, input logic b);
        logic [127:0] r;
        r = v >> 1;
        r[len-1] = b;
        return r;
    endfunction

    assign tdo = (tap == SHDR) ? dr_sr[0] : (tap == SHIR) ? ir_sr[0] : 1'b0;

    always @(posedge tck) begin
        case (tap)
            CAPDR: dr_sr  <= dr_cap;
            SHDR:  dr_sr  <= dr_shift(dr_sr, dr_len, tdi);
            UPDR:  dr_reg <= dr_sr;
            CAPIR: ir_sr  <= 4'h1;
            SHIR:  ir_sr  <= {tdi, ir_sr[3:1]};
            UPIR:  ir_reg <= ir_sr;
            default: ;
        endcase
        tap <= tap_next(tap, tms);
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int           edges;
    int           toggles;
    logic [255:0] seq;
    logic         rsp_err_s;
    logic [127:0] rsp_data_s;

    // Issue one command at a negedge, record tms each cycle until rsp_valid.
    // edges = clock edges from the accept edge to the edge raising rsp_valid.
    task automatic run_cmd(input string tag, input logic [1:0] op,
                           input logic [7:0] len, input logic [127:0] data);
        int   wait_n;
        logic prev;
        logic got;
        wait_n = 0;
        while (!cmd_ready && wait_n < 20) begin
            @(negedge tck);
            wait_n++;
        end
        check({tag, " ready"}, cmd_ready, 1'b1);
        prev      = tms;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(negedge tck);
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_len   = ~len;
        cmd_data  = ~data;
        edges   = 0;
        toggles = 0;
        seq     = '0;
        got     = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (edges < 256) seq[edges] = tms;
            if (tms !== prev) toggles++;
            prev = tms;
            edges++;
            @(negedge tck);
        end
        check({tag, " rsp_seen"}, got, 1'b1);
        check({tag, " ready_low"}, cmd_ready, 1'b0);
        rsp_err_s  = rsp_err;
        rsp_data_s = rsp_data;
        @(negedge tck);
        check({tag, " pulse_1cyc"}, rsp_valid, 1'b0);
        check({tag, " ready_back"}, cmd_ready, 1'b1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [127:0] data128;
    logic [127:0] cap128;
    logic [255:0] exp_seq;
    int           rsp_cnt;

    initial begin
        data128 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        cap128  = 128'h8000_0000_0000_0000_0000_0000_0000_5A5B;

        // Reset: two cycles of trst
        trst = 1'b1;
        repeat (2) @(negedge tck);
        check("rst tms", tms, 1'b1);
        check("rst tdi", tdi, 1'b0);
        check("rst cmd_ready", cmd_ready, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst rsp_valid", rsp_valid, 1'b0);
        check("rst rsp_err", rsp_err, 1'b0);
        check("rst rsp_data", rsp_data, 128'h0);
        trst = 1'b0;
        @(negedge tck);

        // TAP reset command
        run_cmd("op00", 2'b00, 8'd3, 128'h0);
        check("op00 edges", edges, 5);
        check("op00 tms", seq, 256'h1F);
        check("op00 err", rsp_err_s, 1'b0);
        check("op00 data", rsp_data_s, 128'h0);
        check("op00 tap", tap, TLR);

        // DR loopback from TLR
        dr_len = 8;
        dr_cap = 128'h3C;
        run_cmd("dr8", 2'b10, 8'd8, 128'hA5);
        check("dr8 edges", edges, 14);
        check("dr8 tms", seq, 256'h1802);
        check("dr8 err", rsp_err_s, 1'b0);
        check("dr8 data", rsp_data_s, 128'h3C);
        check("dr8 target", dr_reg, 128'hA5);
        check("dr8 tap", tap, RTI);

        // IR scan from RTI
        run_cmd("ir4", 2'b01, 8'd4, 128'h9);
        check("ir4 edges", edges, 10);
        check("ir4 tms", seq, 256'h183);
        check("ir4 data", rsp_data_s, 128'h1);
        check("ir4 target", ir_reg, 4'h9);
        check("ir4 tap", tap, RTI);

        // Single-bit DR: the only bit rides the Exit1 cycle
        dr_cap = 128'h3D;
        run_cmd("dr1", 2'b10, 8'd1, 128'h1);
        check("dr1 edges", edges, 6);
        check("dr1 tms", seq, 256'h19);
        check("dr1 data", rsp_data_s, 128'h1);
        check("dr1 target", dr_reg, 128'h9E);

        // Idle cycles from RTI
        run_cmd("idle3", 2'b11, 8'd3, 128'h0);
        check("idle3 edges", edges, 4);
        check("idle3 tms", seq, 256'h0);
        check("idle3 toggles", toggles, 0);
        check("idle3 err", rsp_err_s, 1'b0);

        // Full-width DR
        dr_len = 128;
        dr_cap = cap128;
        run_cmd("dr128", 2'b10, 8'd128, data128);
        exp_seq      = '0;
        exp_seq[0]   = 1'b1;
        exp_seq[130] = 1'b1;
        exp_seq[131] = 1'b1;
        check("dr128 edges", edges, 133);
        check("dr128 tms", seq, exp_seq);
        check("dr128 data", rsp_data_s, cap128);
        check("dr128 bit127", rsp_data_s[127], 1'b1);
        check("dr128 target", dr_reg, data128);
        check("dr128 tap", tap, RTI);

        // Illegal lengths
        run_cmd("len0", 2'b10, 8'd0, 128'hFF);
        check("len0 edges", edges, 1);
        check("len0 err", rsp_err_s, 1'b1);
        check("len0 toggles", toggles, 0);
        check("len0 data", rsp_data_s, cap128);
        run_cmd("len129", 2'b01, 8'd129, 128'hFF);
        check("len129 edges", edges, 1);
        check("len129 err", rsp_err_s, 1'b1);
        check("len129 toggles", toggles, 0);
        check("len129 data", rsp_data_s, cap128);
        check("len129 tap", tap, RTI);

        // Abort with trst at bit 50 of a 128-bit scan
        check("abort ready", cmd_ready, 1'b1);
        cmd_op    = 2'b10;
        cmd_len   = 8'd128;
        cmd_data  = data128;
        cmd_valid = 1'b1;
        @(negedge tck);
        cmd_valid = 1'b0;
        repeat (53) @(negedge tck);
        check("abort busy", busy, 1'b1);
        check("abort bit50 tdi", tdi, data128[50]);
        check("abort bit50 tms", tms, 1'b0);
        trst = 1'b1;
        @(negedge tck);
        trst = 1'b0;
        check("abort tms", tms, 1'b1);
        check("abort tdi", tdi, 1'b0);
        check("abort busy0", busy, 1'b0);
        check("abort ready1", cmd_ready, 1'b1);
        check("abort data", rsp_data, 128'h0);
        rsp_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            if (rsp_valid) rsp_cnt++;
            @(negedge tck);
        end
        check("abort no_rsp", rsp_cnt, 0);

        run_cmd("op00b", 2'b00, 8'd0, 128'h0);
        check("op00b edges", edges, 5);
        check("op00b tms", seq, 256'h1F);
        check("op00b err", rsp_err_s, 1'b0);
        check("op00b tap", tap, TLR);

        // Idle command leaving TLR
        run_cmd("idle_tlr", 2'b11, 8'd2, 128'h0);
        check("idle_tlr edges", edges, 3);
        check("idle_tlr tms", seq, 256'h0);
        check("idle_tlr toggles", toggles, 1);
        check("idle_tlr tap", tap, RTI);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
